// File: rtl/tpg_pkg.sv
// Shared types and constants for the pixel-stream test-pattern generator.
package tpg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_HRAMP = 2'd0,
    MODE_VRAMP = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  localparam int unsigned CHECK_SHIFT = 3;
  localparam int unsigned FCNT_W      = 16;

  // Counter width for a count of n positions, never below one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    if (n > 1) return unsigned'($clog2(n));
    return 1;
  endfunction

endpackage

// File: rtl/pixel_stream_tpg_if.sv
// Valid/ready pixel-stream bus with frame/line markers.
interface pixel_stream_tpg_if #(
  parameter int unsigned PIX_W = 8
);
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;

  modport master (output m_valid, m_data, m_sof, m_eol, m_eof, input m_ready);
  modport slave  (input m_valid, m_data, m_sof, m_eol, m_eof, output m_ready);
endinterface

// File: rtl/raster_counter.sv
// Raster x/y position tracker; outputs describe the position after this edge's advance.
module raster_counter
  import tpg_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        adv,
  output logic [cnt_w(WIDTH)-1:0]     x_c,
  output logic [cnt_w(HEIGHT)-1:0]    y_c,
  output logic                        sof_c,
  output logic                        eol_c,
  output logic                        eof_c,
  output logic                        wrap_c
);

  localparam int unsigned XW = cnt_w(WIDTH);
  localparam int unsigned YW = cnt_w(HEIGHT);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          last_x;
  logic          last_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (adv) begin
      x_q <= x_c;
      y_q <= y_c;
    end
  end

  // Wrap at end of line / end of frame, then decode markers for the resulting position.
  always_comb begin
    last_x = (x_q == XW'(WIDTH - 1));
    last_y = (y_q == YW'(HEIGHT - 1));
    x_c    = x_q;
    y_c    = y_q;
    wrap_c = 1'b0;
    if (adv) begin
      x_c = last_x ? '0 : x_q + XW'(1);
      if (last_x) y_c = last_y ? '0 : y_q + YW'(1);
      wrap_c = last_x && last_y;
    end
    sof_c = (x_c == '0) && (y_c == '0);
    eol_c = (x_c == XW'(WIDTH - 1));
    eof_c = eol_c && (y_c == YW'(HEIGHT - 1));
  end

endmodule

// File: rtl/pixel_stream_tpg.sv
// Raster test-pattern generator driving a valid/ready pixel stream.
// Build option: TPG_FRAME_INC_EN adds frame_cnt to every pixel for a moving pattern.
module pixel_stream_tpg
  import tpg_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned PIX_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [1:0]          mode,
  input  logic [PIX_W-1:0]    solid_val,
  pixel_stream_tpg_if.master  m,
  output logic                busy,
  output logic [FCNT_W-1:0]   frame_cnt
);

  localparam int unsigned XW = cnt_w(WIDTH);
  localparam int unsigned YW = cnt_w(HEIGHT);

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [PIX_W-1:0]   solid_q, solid_d;
  logic [FCNT_W-1:0]  cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [PIX_W-1:0]   data_q, data_d;
  logic               sof_q, sof_d;
  logic               eol_q, eol_d;
  logic               eof_q, eof_d;
  logic               busy_q, busy_d;

  logic               adv_c;
  logic               load_c;
  logic [PIX_W-1:0]   pat_c;
  logic [XW-1:0]      x_c;
  logic [YW-1:0]      y_c;
  logic               sof_c, eol_c, eof_c, wrap_c;

  assign adv_c = (state_q == RUN) && valid_q && m.m_ready;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk    (clk),
    .reset  (reset),
    .adv    (adv_c),
    .x_c    (x_c),
    .y_c    (y_c),
    .sof_c  (sof_c),
    .eol_c  (eol_c),
    .eof_c  (eof_c),
    .wrap_c (wrap_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_HRAMP;
      solid_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; a new pixel is loaded at frame start and after every non-final transfer.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    solid_d = solid_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    load_c  = 1'b0;
    pat_c   = '0;

    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = RUN;
          mode_d  = mode_t'(mode);
          solid_d = solid_val;
          load_c  = 1'b1;
        end
      end
      RUN: begin
        if (adv_c) begin
          if (wrap_c) begin
            cnt_d = cnt_q + FCNT_W'(1);
            if (run) begin
              mode_d  = mode_t'(mode);
              solid_d = solid_val;
              load_c  = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              data_d  = '0;
              sof_d   = 1'b0;
              eol_d   = 1'b0;
              eof_d   = 1'b0;
            end
          end else begin
            load_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Pattern of the pixel being loaded, using the mode in force for its frame.
    unique case (mode_d)
      MODE_HRAMP: pat_c = PIX_W'(x_c);
      MODE_VRAMP: pat_c = PIX_W'(y_c);
      MODE_CHECK: pat_c = 1'(((32'(x_c) ^ 32'(y_c)) >> CHECK_SHIFT)) ? '1 : '0;
      MODE_SOLID: pat_c = solid_d;
      default:    pat_c = '0;
    endcase
`ifdef TPG_FRAME_INC_EN
    pat_c = pat_c + PIX_W'(cnt_d);
`endif

    if (load_c) begin
      valid_d = 1'b1;
      data_d  = pat_c;
      sof_d   = sof_c;
      eol_d   = eol_c;
      eof_d   = eof_c;
    end

    busy_d = (state_d == RUN);
  end

  assign m.m_valid = valid_q;
  assign m.m_data  = data_q;
  assign m.m_sof   = sof_q;
  assign m.m_eol   = eol_q;
  assign m.m_eof   = eof_q;
  assign busy      = busy_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_pixel_stream_tpg.sv
// Directed bench for pixel_stream_tpg on a 4x2 raster with 8-bit pixels.
module tb_pixel_stream_tpg;

  localparam int W = 4;
  localparam int H = 2;
`ifdef TPG_FRAME_INC_EN
  localparam bit INC = 1'b1;
`else
  localparam bit INC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  solid_val = 8'h00;
  logic        busy;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  pixel_stream_tpg_if #(.PIX_W(8)) ifc ();

  pixel_stream_tpg #(
    .WIDTH  (W),
    .HEIGHT (H),
    .PIX_W  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mode      (mode),
    .solid_val (solid_val),
    .m         (ifc.master),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int m, input int x, input int y,
                                         input logic [7:0] s, input int fc);
    logic [7:0] p;
    case (m)
      0:       p = 8'(x);
      1:       p = 8'(y);
      2:       p = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
      default: p = s;
    endcase
    if (INC) p = 8'(p + 8'(fc));
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input string tag, input int m, input logic [7:0] s, input int fc,
                      input int b, input bit adv);
    int x;
    int y;
    x = b % W;
    y = (b / W) % H;
    check($sformatf("%s_b%0d_valid", tag, b), 32'(ifc.m_valid), 32'(1));
    check($sformatf("%s_b%0d_data", tag, b), 32'(ifc.m_data), 32'(exp_pix(m, x, y, s, fc)));
    check($sformatf("%s_b%0d_sof", tag, b), 32'(ifc.m_sof), 32'(x == 0 && y == 0));
    check($sformatf("%s_b%0d_eol", tag, b), 32'(ifc.m_eol), 32'(x == W - 1));
    check($sformatf("%s_b%0d_eof", tag, b), 32'(ifc.m_eof), 32'(x == W - 1 && y == H - 1));
    check($sformatf("%s_b%0d_busy", tag, b), 32'(busy), 32'(1));
    if (adv) tick();
  endtask

  task automatic start(input int m, input logic [7:0] s);
    mode      = 2'(m);
    solid_val = s;
    run       = 1'b1;
    tick();
  endtask

  // One frame; run is set for the eof decision, mode is scrambled then set for the next frame.
  task automatic frame(input string tag, input int m, input logic [7:0] s, input int fc,
                       input bit run_eof, input int next_m, input logic [7:0] next_s,
                       input int stall_beat);
    for (int b = 0; b < W * H; b++) begin
      if (b == 0) run = run_eof;
      if (b == 1) mode = 2'(m ^ 1);
      if (b == 3) begin
        mode      = 2'(next_m);
        solid_val = next_s;
      end
      if (b == stall_beat) begin
        ifc.m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          beat($sformatf("%s_stall%0d", tag, k), m, s, fc, b, 1'b0);
          tick();
        end
        ifc.m_ready = 1'b1;
      end
      beat(tag, m, s, fc, b, 1'b1);
    end
  endtask

  task automatic idle_check(input string tag, input int fc);
    check({tag, "_valid"}, 32'(ifc.m_valid), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(fc));
    check({tag, "_sof"}, 32'(ifc.m_sof), 32'(0));
    check({tag, "_eol"}, 32'(ifc.m_eol), 32'(0));
    check({tag, "_eof"}, 32'(ifc.m_eof), 32'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    ifc.m_ready = 1'b1;
    do_reset();
    idle_check("reset", 0);
    check("reset_data", 32'(ifc.m_data), 32'(0));

    // Single frame, horizontal ramp, run pulsed
    start(0, 8'h00);
    frame("hramp", 0, 8'h00, 0, 1'b0, 0, 8'h00, -1);
    idle_check("hramp_end", 1);

    // Vertical ramp with a three-cycle stall on beat 5
    start(1, 8'h00);
    frame("vramp", 1, 8'h00, 1, 1'b0, 1, 8'h00, 5);
    idle_check("vramp_end", 2);

    // Three back-to-back frames with no gap
    do_reset();
    start(0, 8'h00);
    frame("b2b0", 0, 8'h00, 0, 1'b1, 0, 8'h00, -1);
    frame("b2b1", 0, 8'h00, 1, 1'b1, 0, 8'h00, -1);
    frame("b2b2", 0, 8'h00, 2, 1'b0, 0, 8'h00, -1);
    idle_check("b2b_end", 3);

    // Solid value changed mid-frame takes effect only on the next frame
    start(3, 8'hA5);
    frame("solid0", 3, 8'hA5, 3, 1'b1, 3, 8'h3C, -1);
    frame("solid1", 3, 8'h3C, 4, 1'b0, 3, 8'h3C, -1);
    idle_check("solid_end", 5);

    // Reset on beat 4 abandons the frame, then a clean restart
    start(0, 8'h00);
    run = 1'b0;
    for (int b = 0; b < 4; b++) beat("abort", 0, 8'h00, 5, b, 1'b1);
    reset = 1'b1;
    tick();
    idle_check("abort_rst", 0);
    check("abort_rst_data", 32'(ifc.m_data), 32'(0));
    reset = 1'b0;
    start(0, 8'h00);
    frame("restart", 0, 8'h00, 0, 1'b0, 0, 8'h00, -1);
    idle_check("restart_end", 1);

    // Two frames from a clean count: second frame shifts when frame increment is built in
    do_reset();
    start(0, 8'h00);
    frame("inc0", 0, 8'h00, 0, 1'b1, 0, 8'h00, -1);
    frame("inc1", 0, 8'h00, 1, 1'b0, 0, 8'h00, -1);
    idle_check("inc_end", 2);

    // Checker on a narrow raster never reaches bit 3, so the frame is flat
    start(2, 8'h00);
    frame("check", 2, 8'h00, 2, 1'b0, 2, 8'h00, -1);
    idle_check("check_end", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
